// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU with single-cycle ops plus iterative multiply and unsigned divide/remainder
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [3:0] op_r;
  logic [WIDTH-1:0] a_r, b_r, acc, addend, fast_res, iter_res, mul_acc;
  logic [WIDTH:0] sum, div_r, div_d;
  logic [SHW-1:0] cnt, sh;
  logic accept, long_op, last, sub, div_ge, fast_c, fast_v;
  assign accept = in_valid && in_ready;
  assign long_op = ALUControl >= 4'd10 && ALUControl <= 4'd12;
  assign last = cnt == SHW'(WIDTH - 1);
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = long_op ? BUSY : DONE;
    else if (state == BUSY && last) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_comb begin
    sub = ALUControl == 4'd1;
    addend = sub ? ~srcB : srcB;
    sum = {1'b0, srcA} + {1'b0, addend} + (WIDTH + 1)'(sub);
    sh = srcB[SHW-1:0];
    fast_c = ALUControl <= 4'd1 && sum[WIDTH];
    fast_v = ALUControl <= 4'd1 && srcA[WIDTH-1] == addend[WIDTH-1] && sum[WIDTH-1] != srcA[WIDTH-1];
    case (ALUControl)
      4'd0, 4'd1: fast_res = sum[WIDTH-1:0];
      4'd2:       fast_res = srcA & srcB;
      4'd3:       fast_res = srcA | srcB;
      4'd4:       fast_res = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      4'd5:       fast_res = {{(WIDTH-1){1'b0}}, srcA < srcB};
      4'd6:       fast_res = srcA ^ srcB;
      4'd7:       fast_res = srcA << sh;
      4'd8:       fast_res = srcA >> sh;
      4'd9:       fast_res = WIDTH'($signed(srcA) >>> sh);
      default:    fast_res = '0;
    endcase
  end
  // a_r/b_r double as multiplicand/multiplier or quotient-shift/divisor; acc as product or remainder
  always_comb begin
    mul_acc = acc + (b_r[0] ? a_r : '0);
    div_r = {acc, a_r[WIDTH-1]};
    div_ge = div_r >= {1'b0, b_r};
    div_d = div_ge ? div_r - {1'b0, b_r} : div_r;
    iter_res = op_r == 4'd10 ? mul_acc : op_r == 4'd11 ? {a_r[WIDTH-2:0], div_ge} : div_d[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
      ALUResult <= '0;
      zero <= 1'b1;
      negative <= 1'b0;
      carry <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_r <= ALUControl;
      a_r <= srcA;
      b_r <= srcB;
      acc <= '0;
      cnt <= '0;
      if (!long_op) begin
        ALUResult <= fast_res;
        zero <= fast_res == '0;
        negative <= fast_res[WIDTH-1];
        carry <= fast_c;
        overflow <= fast_v;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      if (op_r == 4'd10) begin
        acc <= mul_acc;
        a_r <= a_r << 1;
        b_r <= b_r >> 1;
      end else begin
        acc <= div_d[WIDTH-1:0];
        a_r <= {a_r[WIDTH-2:0], div_ge};
      end
      if (last) begin
        ALUResult <= iter_res;
        zero <= iter_res == '0;
        negative <= iter_res[WIDTH-1];
        carry <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end
endmodule
